// File: rtl/can_bit_destuffer.sv
// can_bit_destuffer
//
// Watches the sampled CAN bus bit at every sample point. It tells the
// downstream frame store which bits are stuff bits so they can be dropped,
// and it reports a stuff-rule violation. It also tracks bus integration:
// it waits for an idle bus after reset or an error, detects start-of-frame,
// and follows the frame until the decoder signals its end.
//
// Ports
//   sp           in   sample-point clock, rising edge active
//   reset        in   synchronous, active-high reset
//   CAN_RX       in   sampled bus bit (0 = dominant, 1 = recessive)
//   stuff_en     in   stuffing region active (SOF through last CRC bit)
//   frame_end    in   1-sp pulse from the frame decoder, frame finished
//   isStuff      out  current CAN_RX bit is a stuff bit
//   stuff_error  out  registered 1-sp pulse, stuff bit matched the preceding run
//   sof          out  registered 1-sp pulse in the sp cycle after SOF was sampled
//   bus_idle     out  high while the bus is integrated and idle
//
// state  | meaning
// -------+-------------------------------------------------------------
// SYNC   | integrating after reset or error, counting recessive bits
// IDLE   | bus idle, waiting for a dominant SOF bit
// ACTIVE | inside a frame, tracking runs of equal bits

module can_bit_destuffer #(
   parameter int STUFF_LEN = 5,
   parameter int IDLE_LEN  = 11
) (
   input  logic sp,
   input  logic reset,
   input  logic CAN_RX,
   input  logic stuff_en,
   input  logic frame_end,
   output logic isStuff,
   output logic stuff_error,
   output logic sof,
   output logic bus_idle
);

   typedef enum logic [1:0] {
      SYNC   = 2'd0,
      IDLE   = 2'd1,
      ACTIVE = 2'd2
   } state_t;

   localparam logic [2:0] RUN_MAX = 3'(STUFF_LEN);
   localparam logic [3:0] REC_MAX = 4'(IDLE_LEN);
   localparam logic [3:0] REC_SAT = 4'hF;

   state_t     state;
   logic [2:0] run_cnt;
   logic [3:0] rec_cnt;
   logic       last_bit;

   logic       stuff_slot;
   logic       violation;

   // A stuff bit is only expected while the decoder says stuffing applies;
   // with stuff_en low the run counter keeps saturating but never triggers.
   assign stuff_slot = (state == ACTIVE) && stuff_en && (run_cnt == RUN_MAX);
   assign violation  = stuff_slot && (CAN_RX == last_bit);

   assign isStuff  = stuff_slot;
   assign bus_idle = (state == IDLE);

   always_ff @(posedge sp) begin
      if (reset) begin
         state       <= SYNC;
         run_cnt     <= 3'd0;
         rec_cnt     <= 4'd0;
         last_bit    <= 1'b1;
         stuff_error <= 1'b0;
         sof         <= 1'b0;
      end else begin
         stuff_error <= 1'b0;
         sof         <= 1'b0;
         case (state)
            SYNC: begin
               if (CAN_RX) begin
                  if (rec_cnt != REC_SAT) begin
                     rec_cnt <= rec_cnt + 4'd1;
                  end
                  // The bit being sampled now is the IDLE_LEN-th recessive one.
                  if (rec_cnt >= REC_MAX - 4'd1) begin
                     state <= IDLE;
                  end
               end else begin
                  rec_cnt <= 4'd0;
               end
            end

            IDLE: begin
               if (!CAN_RX) begin
                  // The SOF bit itself opens the first run of dominant bits.
                  state    <= ACTIVE;
                  last_bit <= 1'b0;
                  run_cnt  <= 3'd1;
                  sof      <= 1'b1;
               end
            end

            ACTIVE: begin
               if (violation) begin
                  // Violation takes priority over a coincident frame_end.
                  stuff_error <= 1'b1;
                  state       <= SYNC;
                  rec_cnt     <= 4'd0;
               end else if (frame_end) begin
                  state   <= IDLE;
                  run_cnt <= 3'd0;
               end else if (stuff_slot) begin
                  last_bit <= CAN_RX;
                  run_cnt  <= 3'd1;
               end else begin
                  if (CAN_RX == last_bit) begin
                     if (run_cnt < RUN_MAX) begin
                        run_cnt <= run_cnt + 3'd1;
                     end
                  end else begin
                     run_cnt <= 3'd1;
                  end
                  last_bit <= CAN_RX;
               end
            end

            default: begin
               state <= SYNC;
            end
         endcase
      end
   end

endmodule
